// File: rtl/srt2_divider_seq_pkg.sv
// Shared types for the SRT radix-2 divider: sequencer states and quotient-digit selection.
package srt2_divider_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_CORR,
        S_FIN,
        S_DZ
    } state_e;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_POS,
        SEL_NEG
    } sel_e;

    // Digit choice from the top three bits of the partial remainder: small magnitude keeps 0.
    function automatic sel_e srt_select(input logic [2:0] top);
        sel_e sel;
        if (top == 3'b000 || top == 3'b111) begin
            sel = SEL_ZERO;
        end else if (top[2]) begin
            sel = SEL_NEG;
        end else begin
            sel = SEL_POS;
        end
        return sel;
    endfunction

endpackage

// File: rtl/srt2_lzc.sv
// Combinational leading-zero count; the divider never presents an all-zero value.
module srt2_lzc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         value_i,
    output logic [$clog2(WIDTH)-1:0] count_o
);
    localparam int LZW = $clog2(WIDTH);

    // Scanning upward lets the highest set bit have the last word.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value_i[i]) begin
                count_o = LZW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/srt2_divider_seq.sv
// Self-sequenced SRT radix-2 divider with start/done handshake, signed mode and exception flags.
module srt2_divider_seq
    import srt2_divider_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int LZW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [LZW-1:0]   cnt_q, cnt_d;
    logic [LZW-1:0]   lz_q, lz_d;
    logic             neg_dd_q, neg_dd_d;
    logic             neg_dv_q, neg_dv_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [LZW-1:0]     lz_w;
    logic [2*WIDTH:0]   norm_wide;
    sel_e               sel;
    logic [WIDTH:0]     shifted_a;
    logic [WIDTH:0]     m_ext;
    logic               sub_en;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   qmag;
    logic [WIDTH-1:0]   rmag;
    logic [WIDTH-1:0]   dz_dividend;
    logic               in_neg_dd;
    logic               in_neg_dv;

    srt2_lzc #(.WIDTH(WIDTH)) u_lzc (
        .value_i (m_q),
        .count_o (lz_w)
    );

    // One adder serves both the iteration step and the final negative-remainder fix-up.
    assign sel         = srt_select(a_q[WIDTH:WIDTH-2]);
    assign shifted_a   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign m_ext       = {1'b0, m_q};
    assign sub_en      = (state_q == S_ITER) && (sel == SEL_POS);
    assign add_a       = (state_q == S_ITER) ? shifted_a : a_q;
    assign add_b       = sub_en ? ~m_ext : m_ext;
    assign sum         = add_a + add_b + {{WIDTH{1'b0}}, sub_en};
    assign norm_wide   = {{(WIDTH+1){1'b0}}, q_q} << lz_w;
    assign qmag        = q_q - qs_q;
    assign rmag        = WIDTH'(a_q >> lz_q);
    assign dz_dividend = neg_dd_q ? -q_q : q_q;
    assign in_neg_dd   = signed_mode & dividend[WIDTH-1];
    assign in_neg_dv   = signed_mode & divisor[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            q_q        <= '0;
            qs_q       <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            lz_q       <= '0;
            neg_dd_q   <= 1'b0;
            neg_dv_q   <= 1'b0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            q_q        <= q_d;
            qs_q       <= qs_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            lz_q       <= lz_d;
            neg_dd_q   <= neg_dd_d;
            neg_dv_q   <= neg_dv_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

    // A start arriving during the done cycle is dropped, hence the done_q guard in IDLE.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        q_d        = q_q;
        qs_d       = qs_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        lz_d       = lz_q;
        neg_dd_d   = neg_dd_q;
        neg_dv_d   = neg_dv_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    neg_dd_d   = in_neg_dd;
                    neg_dv_d   = in_neg_dv;
                    q_d        = in_neg_dd ? -dividend : dividend;
                    m_d        = in_neg_dv ? -divisor : divisor;
                    ovf_pend_d = signed_mode && (dividend == MIN_VAL) && (divisor == '1);
                    dz_d       = 1'b0;
                    ovf_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = (divisor == '0) ? S_DZ : S_NORM;
                end
            end
            S_NORM: begin
                m_d     = m_q << lz_w;
                a_d     = norm_wide[2*WIDTH:WIDTH];
                q_d     = norm_wide[WIDTH-1:0];
                qs_d    = '0;
                cnt_d   = '0;
                lz_d    = lz_w;
                state_d = S_ITER;
            end
            S_ITER: begin
                a_d   = (sel == SEL_ZERO) ? shifted_a : sum;
                q_d   = {q_q[WIDTH-2:0], sel == SEL_POS};
                qs_d  = {qs_q[WIDTH-2:0], sel == SEL_NEG};
                cnt_d = cnt_q + LZW'(1);
                if (cnt_q == LZW'(WIDTH - 1)) begin
                    state_d = S_CORR;
                end
            end
            S_CORR: begin
                if (a_q[WIDTH]) begin
                    a_d  = sum;
                    qs_d = qs_q + WIDTH'(1);
                end
                state_d = S_FIN;
            end
            S_FIN: begin
                if (ovf_pend_q) begin
                    quot_d = MIN_VAL;
                    rem_d  = '0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = (neg_dd_q ^ neg_dv_q) ? -qmag : qmag;
                    rem_d  = neg_dd_q ? -rmag : rmag;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_DZ: begin
                // Two cycles here so the zero-divisor result appears after the second edge.
                if (cnt_q == '0) begin
                    cnt_d = LZW'(1);
                end else begin
                    quot_d  = '1;
                    rem_d   = dz_dividend;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE) || done_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_srt2_divider_seq.sv
// Bench for srt2_divider_seq: directed scenarios plus random sweeps against an arithmetic / and % model.
module tb_srt2_divider_seq;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  dvd8 = '0, dvs8 = '0;
    logic        busy8, done8, dz8, ovf8;
    logic [7:0]  quot8, rem8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] dvd16 = '0, dvs16 = '0;
    logic        busy16, done16, dz16, ovf16;
    logic [15:0] quot16, rem16;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    srt2_divider_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(sm8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .quotient(quot8), .remainder(rem8), .div_by_zero(dz8), .overflow(ovf8)
    );

    srt2_divider_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_b(rst_b), .start(start16), .signed_mode(sm16),
        .dividend(dvd16), .divisor(dvs16), .busy(busy16), .done(done16),
        .quotient(quot16), .remainder(rem16), .div_by_zero(dz16), .overflow(ovf16)
    );

    // Reference: plain integer division, C-style truncation, remainder takes the dividend's sign.
    function automatic void model(input int w, input logic sm, input longint a, input longint b,
                                  output longint q, output longint r, output logic dz, output logic ov);
        longint full;
        longint sa;
        longint sb;
        full = longint'(1) << w;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q = full - 1;
            r = a;
            dz = 1'b1;
        end else if (!sm) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = (a >= full / 2) ? a - full : a;
            sb = (b >= full / 2) ? b - full : b;
            if (sa == -(full / 2) && sb == -1) begin
                ov = 1'b1;
                q = full / 2;
                r = 0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end
        q = q & (full - 1);
        r = r & (full - 1);
    endfunction

    task automatic do_op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic dz,
                          output logic ov, output int lat, output logic busy_ok);
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; dvd8 = a; dvs8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        busy_ok = (busy8 === 1'b1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (busy8 !== 1'b1) busy_ok = 1'b0;
            if (done8 === 1'b1) begin
                lat = k;
                break;
            end
        end
        q = quot8; r = rem8; dz = dz8; ov = ovf8;
        @(posedge clk); #1;
        if (busy8 !== 1'b0 || done8 !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic do_op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r, output logic dz,
                           output logic ov, output int lat);
        @(negedge clk);
        start16 = 1'b1; sm16 = sm; dvd16 = a; dvs16 = b;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done16 === 1'b1) begin
                lat = k;
                break;
            end
        end
        q = quot16; r = rem16; dz = dz16; ov = ovf16;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy8, done8} !== 2'b00) $display("[TB] FAIL reset_busy_done8: got %b required 00", {busy8, done8}); else passes++;
        checks++; if ({quot8, rem8} !== 16'h0000) $display("[TB] FAIL reset_results8: got %h required 0000", {quot8, rem8}); else passes++;
        checks++; if ({dz8, ovf8} !== 2'b00) $display("[TB] FAIL reset_flags8: got %b required 00", {dz8, ovf8}); else passes++;
        checks++; if ({busy16, done16, dz16, ovf16, quot16, rem16} !== 36'h0) $display("[TB] FAIL reset_all16: got %h required 0", {busy16, done16, dz16, ovf16, quot16, rem16}); else passes++;
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    task automatic test_unsigned_basic();
        logic [7:0] q, r; logic dz, ov, bok; int lat;
        do_op8(1'b0, 8'd100, 8'd7, q, r, dz, ov, lat, bok);
        checks++; if (q !== 8'd14) $display("[TB] FAIL u100_7_quot: got %0d required 14", q); else passes++;
        checks++; if (r !== 8'd2) $display("[TB] FAIL u100_7_rem: got %0d required 2", r); else passes++;
        checks++; if ({dz, ov} !== 2'b00) $display("[TB] FAIL u100_7_flags: got %b required 00", {dz, ov}); else passes++;
        checks++; if (lat !== 11) $display("[TB] FAIL u100_7_latency: got %0d required 11", lat); else passes++;
        checks++; if (bok !== 1'b1) $display("[TB] FAIL u100_7_busy_window: got %b required 1", bok); else passes++;
    endtask

    task automatic test_signed();
        logic [7:0] q, r; logic dz, ov, bok; int lat;
        do_op8(1'b1, 8'h9C, 8'h07, q, r, dz, ov, lat, bok);
        checks++; if ({q, r} !== 16'hF2FE) $display("[TB] FAIL s_m100_7: got %h required F2FE", {q, r}); else passes++;
        checks++; if (ov !== 1'b0) $display("[TB] FAIL s_m100_7_ovf: got %b required 0", ov); else passes++;
        do_op8(1'b1, 8'd100, 8'hF9, q, r, dz, ov, lat, bok);
        checks++; if ({q, r} !== 16'hF202) $display("[TB] FAIL s_100_m7: got %h required F202", {q, r}); else passes++;
        checks++; if (lat !== 11) $display("[TB] FAIL s_100_m7_latency: got %0d required 11", lat); else passes++;
    endtask

    task automatic test_div_by_zero();
        logic [7:0] q, r; logic dz, ov, bok; int lat;
        for (int m = 0; m < 2; m++) begin
            do_op8(m[0], 8'h55, 8'h00, q, r, dz, ov, lat, bok);
            checks++; if ({q, r} !== 16'hFF55) $display("[TB] FAIL dz_results_mode%0d: got %h required FF55", m, {q, r}); else passes++;
            checks++; if ({dz, ov} !== 2'b10) $display("[TB] FAIL dz_flags_mode%0d: got %b required 10", m, {dz, ov}); else passes++;
            checks++; if (lat !== 2) $display("[TB] FAIL dz_latency_mode%0d: got %0d required 2", m, lat); else passes++;
            checks++; if (bok !== 1'b1) $display("[TB] FAIL dz_busy_window_mode%0d: got %b required 1", m, bok); else passes++;
        end
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++; if (dz8 !== 1'b0) $display("[TB] FAIL dz_clear_on_start: got %b required 0", dz8); else passes++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) break;
        end
        checks++; if ({done8, quot8} !== {1'b1, 8'd14}) $display("[TB] FAIL dz_followup_quot: got %h required 10E", {done8, quot8}); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [7:0] q, r; logic dz, ov, bok; int lat;
        do_op8(1'b1, 8'h80, 8'hFF, q, r, dz, ov, lat, bok);
        checks++; if ({q, r} !== 16'h8000) $display("[TB] FAIL ovf_signed_results: got %h required 8000", {q, r}); else passes++;
        checks++; if ({dz, ov} !== 2'b01) $display("[TB] FAIL ovf_signed_flags: got %b required 01", {dz, ov}); else passes++;
        checks++; if (lat !== 11) $display("[TB] FAIL ovf_signed_latency: got %0d required 11", lat); else passes++;
        do_op8(1'b0, 8'h80, 8'hFF, q, r, dz, ov, lat, bok);
        checks++; if ({q, r} !== 16'h0080) $display("[TB] FAIL ovf_unsigned_results: got %h required 0080", {q, r}); else passes++;
        checks++; if (ov !== 1'b0) $display("[TB] FAIL ovf_unsigned_flag: got %b required 0", ov); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; dvd8 = 8'd200; dvs8 = 8'd9;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin start8 = 1'b1; sm8 = 1'b1; dvd8 = 8'h9C; dvs8 = 8'h00; end
            if (k == 4) start8 = 1'b0;
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 11) $display("[TB] FAIL ignore_busy_latency: got %0d required 11", lat); else passes++;
        checks++; if ({quot8, rem8, dz8} !== {8'd22, 8'd2, 1'b0}) $display("[TB] FAIL ignore_busy_results: got %h required %h", {quot8, rem8, dz8}, {8'd22, 8'd2, 1'b0}); else passes++;
        start8 = 1'b1; sm8 = 1'b0; dvd8 = 8'h55; dvs8 = 8'h00;
        @(posedge clk); #1;
        checks++; if ({busy8, done8} !== 2'b00) $display("[TB] FAIL ignore_done_cycle: got %b required 00", {busy8, done8}); else passes++;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++; if (busy8 !== 1'b1) $display("[TB] FAIL accept_after_done: got %b required 1", busy8); else passes++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) break;
        end
        checks++; if ({done8, dz8, quot8, rem8} !== {2'b11, 16'hFF55}) $display("[TB] FAIL accept_after_done_result: got %h required %h", {done8, dz8, quot8, rem8}, {2'b11, 16'hFF55}); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [7:0] q, r; logic dz, ov, bok; int lat; int seen;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy8, done8} !== 2'b00) $display("[TB] FAIL abort_busy_done: got %b required 00", {busy8, done8}); else passes++;
        checks++; if ({quot8, rem8, dz8, ovf8} !== 18'h0) $display("[TB] FAIL abort_outputs: got %h required 0", {quot8, rem8, dz8, ovf8}); else passes++;
        @(negedge clk);
        rst_b = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen++;
        end
        checks++; if (seen !== 0) $display("[TB] FAIL abort_no_done: got %0d active cycles required 0", seen); else passes++;
        do_op8(1'b0, 8'd255, 8'd1, q, r, dz, ov, lat, bok);
        checks++; if ({q, r} !== 16'hFF00) $display("[TB] FAIL u255_1: got %h required FF00", {q, r}); else passes++;
    endtask

    task automatic test_random8();
        logic [7:0] q, r, a, b; logic dz, ov, bok, sm; int lat;
        longint eq, er; logic edz, eov; int elat;
        for (int n = 0; n < 60; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            sm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) b = 8'h00;
            if ($urandom_range(0, 9) == 1) begin a = 8'h80; b = 8'hFF; end
            model(8, sm, longint'(a), longint'(b), eq, er, edz, eov);
            elat = edz ? 2 : 11;
            do_op8(sm, a, b, q, r, dz, ov, lat, bok);
            checks++;
            if ({q, r, dz, ov} !== {eq[7:0], er[7:0], edz, eov})
                $display("[TB] FAIL rand8 sm=%0d %0d/%0d: got q=%0d r=%0d dz=%b ov=%b required q=%0d r=%0d dz=%b ov=%b",
                         sm, a, b, q, r, dz, ov, eq[7:0], er[7:0], edz, eov);
            else passes++;
            checks++;
            if (lat !== elat || bok !== 1'b1)
                $display("[TB] FAIL rand8_timing %0d/%0d: got latency %0d busy_ok %b required %0d 1", a, b, lat, bok, elat);
            else passes++;
        end
    endtask

    task automatic test_wide16();
        logic [15:0] q, r, a, b; logic dz, ov, sm; int lat;
        longint eq, er; logic edz, eov;
        do_op16(1'b0, 16'd1000, 16'd3, q, r, dz, ov, lat);
        checks++; if ({q, r} !== {16'd333, 16'd1}) $display("[TB] FAIL w16_1000_3: got %0d r %0d required 333 r 1", q, r); else passes++;
        checks++; if (lat !== 19) $display("[TB] FAIL w16_latency: got %0d required 19", lat); else passes++;
        for (int n = 0; n < 30; n++) begin
            a = 16'($urandom_range(0, 65535));
            b = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 65535));
            sm = 1'($urandom_range(0, 1));
            if (n == 7) begin a = 16'h8000; b = 16'hFFFF; sm = 1'b1; end
            model(16, sm, longint'(a), longint'(b), eq, er, edz, eov);
            do_op16(sm, a, b, q, r, dz, ov, lat);
            checks++;
            if ({q, r, dz, ov} !== {eq[15:0], er[15:0], edz, eov} || lat !== (edz ? 2 : 19))
                $display("[TB] FAIL rand16 sm=%0d %0d/%0d: got q=%0d r=%0d dz=%b ov=%b lat=%0d required q=%0d r=%0d dz=%b ov=%b",
                         sm, a, b, q, r, dz, ov, lat, eq[15:0], er[15:0], edz, eov);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_random8();
        test_wide16();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
